// File: rtl/spi_readout_pkg.sv
// Package for the SPI readout host: FSM state encoding and register-map constants.
// Optional feature macro used by the importing files: READOUT_ADDR_TAG_EN.
package spi_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    CMD,
    DATA,
    TRAIL,
    GAP
  } state_t;

  // Bit 7 of the command byte: 1 = read.
  localparam logic RD_CMD_BIT = 1'b1;
  // Register map: addresses 0..N_SPI_REGS-1 are SPI registers, CH_BASE and up are
  // channel timestamps.
  localparam int N_SPI_REGS = 10;
  localparam int CH_BASE    = 10;

endpackage

// File: rtl/spi_readout_host_clk_gen.sv
// spi_clk_gen: half-period counter and SPI clock generator for spi_readout_host.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   en_i         counter runs while high, held at zero while low
//   tgl_en_i     spi_clk toggles on each tick while high
//   tick_o       one-clk strobe each time the half-period counter wraps
//   rise_o       spi_clk goes high on this clk edge
//   fall_o       spi_clk goes low on this clk edge
//   spi_clk_o    registered SPI clock (mode 0, idles low)
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic tgl_en_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic spi_clk_o
);

  localparam int HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HP_W-1:0] HP_MAX = HP_W'(CLK_DIV - 1);

  logic [HP_W-1:0] hp_cnt_q;
  logic            spi_clk_q;

  assign tick_o    = en_i && (hp_cnt_q == HP_MAX);
  // Edge strobes describe the transition happening at the end of this cycle.
  assign rise_o    = tick_o && tgl_en_i && !spi_clk_q;
  assign fall_o    = tick_o && tgl_en_i && spi_clk_q;
  assign spi_clk_o = spi_clk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_cnt_q  <= '0;
      spi_clk_q <= 1'b0;
    end else begin
      if (!en_i || tick_o) hp_cnt_q <= '0;
      else                 hp_cnt_q <= hp_cnt_q + 1'b1;

      if (!en_i)                   spi_clk_q <= 1'b0;
      else if (tick_o && tgl_en_i) spi_clk_q <= ~spi_clk_q;
    end
  end

endmodule

// File: rtl/spi_readout_host.sv
// spi_readout_host: SPI host that reads a burst of bytes from the chip's register /
// timestamp map. Sends {read flag, start address} on pico, then clocks req_len+1
// bytes in from poci (the peripheral auto-increments its address per byte).
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_addr, req_len     first address, byte count minus one
//   rd_data/rd_valid      received byte and its one-clk strobe (no backpressure)
//   rd_last               marks the final byte of the burst
//   busy                  high from acceptance until back in IDLE
//   spi_clk, cs, pico     SPI outputs (mode 0, cs active high)
//   poci                  SPI input, already synchronised to clk
//   rd_addr               (READOUT_ADDR_TAG_EN only) address of the byte in rd_data
module spi_readout_host
  import spi_readout_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7,
  parameter int LEN_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              spi_clk,
  output logic              cs,
  output logic              pico,
  input  logic              poci
`ifdef READOUT_ADDR_TAG_EN
  ,
  output logic [ADDR_W-1:0] rd_addr
`endif
);

  localparam int CMD_W = ADDR_W + 1;

  state_t             state_q, state_d;
  logic               cs_q, cs_d, pico_q, pico_d;
  logic               ready_q, ready_d, busy_q, busy_d;
  logic               vld_q, vld_d, last_q, last_d, gap_q, gap_d;
  logic [CMD_W-1:0]   cmd_sr_q, cmd_sr_d;
  logic [7:0]         rx_sr_q, rx_sr_d, rd_data_q, rd_data_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [LEN_W:0]     byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               clk_en, tgl_en, tick, rise, fall, is_last;
`ifdef READOUT_ADDR_TAG_EN
  logic [ADDR_W-1:0]  tag_q, tag_d, rd_addr_q, rd_addr_d;
`endif

  assign clk_en  = (state_q != IDLE);
  assign tgl_en  = (state_q == CMD) || (state_q == DATA);
  assign is_last = (byte_cnt_q == {1'b0, len_q});

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en_i      (clk_en),
    .tgl_en_i  (tgl_en),
    .tick_o    (tick),
    .rise_o    (rise),
    .fall_o    (fall),
    .spi_clk_o (spi_clk)
  );

  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    pico_d     = pico_q;
    cmd_sr_d   = cmd_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    gap_d      = gap_q;
    rd_data_d  = rd_data_q;
    vld_d      = 1'b0;
    last_d     = 1'b0;
`ifdef READOUT_ADDR_TAG_EN
    tag_d      = tag_q;
    rd_addr_d  = rd_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          len_d      = req_len;
          // Bit 7 goes straight onto pico; the address bits follow on falling edges.
          pico_d     = RD_CMD_BIT;
          cmd_sr_d   = {req_addr, 1'b0};
          cs_d       = 1'b1;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          gap_d      = 1'b0;
`ifdef READOUT_ADDR_TAG_EN
          tag_d      = req_addr;
`endif
          state_d    = LEAD;
        end
      end
      LEAD: begin
        if (tick) state_d = CMD;
      end
      CMD: begin
        if (fall) begin
          pico_d    = cmd_sr_q[CMD_W-1];
          cmd_sr_d  = cmd_sr_q << 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            pico_d  = 1'b0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rise) rx_sr_d = {rx_sr_q[6:0], poci};
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          // A byte is complete at the falling edge that closes its 8th spi_clk cycle.
          if (bit_cnt_q == 3'd7) begin
            vld_d      = 1'b1;
            rd_data_d  = rx_sr_q;
            last_d     = is_last;
            byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef READOUT_ADDR_TAG_EN
            rd_addr_d  = tag_q;
            tag_d      = tag_q + 1'b1;
`endif
            if (is_last) state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_d    = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        // Two ticks with cs low so the peripheral resets its address register.
        if (tick) begin
          gap_d = 1'b1;
          if (gap_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cs_q       <= 1'b0;
      pico_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      gap_q      <= 1'b0;
      cmd_sr_q   <= '0;
      rx_sr_q    <= '0;
      rd_data_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
`ifdef READOUT_ADDR_TAG_EN
      tag_q      <= '0;
      rd_addr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      pico_q     <= pico_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      gap_q      <= gap_d;
      cmd_sr_q   <= cmd_sr_d;
      rx_sr_q    <= rx_sr_d;
      rd_data_q  <= rd_data_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
`ifdef READOUT_ADDR_TAG_EN
      tag_q      <= tag_d;
      rd_addr_q  <= rd_addr_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign cs        = cs_q;
  assign pico      = pico_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = vld_q;
  assign rd_last   = last_q;
`ifdef READOUT_ADDR_TAG_EN
  assign rd_addr   = rd_addr_q;
`endif

endmodule

// File: tb/tb_spi_readout_host.sv
module tb_spi_readout_host;
  import spi_readout_pkg::*;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready;
  logic [6:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] rd_data;
  logic       rd_valid, rd_last, busy, spi_clk, cs, pico, poci;
`ifdef READOUT_ADDR_TAG_EN
  logic [6:0] rd_addr;
`endif

  spi_readout_host #(.CLK_DIV(4), .ADDR_W(7), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .busy      (busy),
    .spi_clk   (spi_clk),
    .cs        (cs),
    .pico      (pico),
    .poci      (poci)
`ifdef READOUT_ADDR_TAG_EN
    ,
    .rd_addr   (rd_addr)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]       addr;
    logic [3:0]       len;
    logic [15:0][7:0] bytes;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [6:0] addr;
  } exp_t;

  vec_t       vecs [5];
  exp_t       sb [$];
  logic [7:0] mem [128];

  int   n_cmp = 0, n_err = 0, n_valid = 0;
  int   total_rises = 0, cs_rises = 0, m_rises = 0;
  logic [7:0] m_cmd = 8'h00, m_cur = 8'h00;
  logic [6:0] m_addr = 7'd0;
  logic prev_sclk = 1'b0, prev_cs = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Peripheral model: captures the command on spi_clk rises, shifts data out on falls.
  task automatic model();
    int dr;
    if (!cs) begin
      m_rises = 0;
      poci    = 1'b0;
    end else if (spi_clk && !prev_sclk) begin
      if (m_rises < 8) m_cmd = {m_cmd[6:0], pico};
      m_rises++;
      total_rises++;
    end else if (!spi_clk && prev_sclk) begin
      if (m_rises == 8) begin
        m_addr = m_cmd[6:0];
        m_cur  = mem[m_addr];
        poci   = m_cur[7];
      end else if (m_rises > 8) begin
        dr = (m_rises - 8) % 8;
        if (dr == 0) begin
          m_addr = m_addr + 7'd1;
          m_cur  = mem[m_addr];
        end
        poci = m_cur[7-dr];
      end
    end
    if (cs && !prev_cs) cs_rises++;
    prev_sclk = spi_clk;
    prev_cs   = cs;
  endtask

  task automatic monitor();
    exp_t e;
    if (rd_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rd_valid: got data %0h required no output", rd_data);
      end else begin
        e = sb.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.data));
        chk("rd_last", 32'(rd_last), 32'(e.last));
`ifdef READOUT_ADDR_TAG_EN
        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
`endif
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model();
    monitor();
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 128; a++) mem[a] = 8'h00;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l, input logic [6:0] a);
    exp_t e;
    e.data = d;
    e.last = l;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic wait_accept();
    int t = 0;
    while (!req_ready && t < 3000) begin
      step();
      t++;
    end
    if (!req_ready) tmo("accept");
    step();
    req_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 4000) begin
      step();
      t++;
    end
    if (busy) tmo("idle");
  endtask

  task automatic do_burst(input int i);
    vec_t v;
    v = vecs[i];
    clear_mem();
    for (int k = 0; k <= int'(v.len); k++) begin
      mem[v.addr + 7'(k)] = v.bytes[k];
      push_exp(v.bytes[k], (k == int'(v.len)), v.addr + 7'(k));
    end
    total_rises = 0;
    req_addr  = v.addr;
    req_len   = v.len;
    req_valid = 1'b1;
    wait_accept();
    wait_idle();
    chk("cmd_byte", 32'(m_cmd), 32'({1'b1, v.addr}));
    chk("spi_clk_rises", total_rises, 8 + 8 * (int'(v.len) + 1));
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int base;
    int t;
    for (int i = 0; i < 5; i++) vecs[i] = '0;
    vecs[0].addr = 7'd3;  vecs[0].len = 4'd0; vecs[0].bytes[0] = 8'hA5;
    vecs[1].addr = 7'(CH_BASE + 6); vecs[1].len = 4'd3;
    vecs[1].bytes[0] = 8'h11; vecs[1].bytes[1] = 8'h22;
    vecs[1].bytes[2] = 8'h33; vecs[1].bytes[3] = 8'h44;
    vecs[2].addr = 7'd126; vecs[2].len = 4'd3;
    vecs[2].bytes[0] = 8'hC3; vecs[2].bytes[1] = 8'h3C;
    vecs[3].addr = 7'd40; vecs[3].len = 4'd15;
    for (int k = 0; k < 16; k++) vecs[3].bytes[k] = 8'($urandom_range(0, 255));
    vecs[4].addr = 7'(N_SPI_REGS - 1); vecs[4].len = 4'd1;
    vecs[4].bytes[0] = 8'h5A; vecs[4].bytes[1] = 8'h0F;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; poci = 1'b0;
    clear_mem();
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cs", 32'(cs), 0);
    chk("rst_spi_clk", 32'(spi_clk), 0);
    chk("rst_pico", 32'(pico), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_last", 32'(rd_last), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(req_ready), 1);

    for (int i = 0; i < 5; i++) do_burst(i);

    // Second request while busy is ignored until the first burst completes.
    clear_mem();
    mem[20] = 8'h6B; mem[21] = 8'hD4; mem[30] = 8'h99;
    push_exp(8'h6B, 1'b0, 7'd20);
    push_exp(8'hD4, 1'b1, 7'd21);
    push_exp(8'h99, 1'b1, 7'd30);
    cs_rises = 0;
    base = n_valid;
    req_addr = 7'd20; req_len = 4'd1; req_valid = 1'b1;
    wait_accept();
    repeat (4) step();
    req_addr = 7'd30; req_len = 4'd0; req_valid = 1'b1;
    step();
    chk("ready_while_busy", 32'(req_ready), 0);
    t = 0;
    while (!req_ready && t < 3000) begin
      step();
      t++;
    end
    if (!req_ready) tmo("second_ready");
    chk("bursts_before_second", cs_rises, 1);
    chk("valids_first_burst", n_valid - base, 2);
    step();
    req_valid = 1'b0;
    wait_idle();
    chk("bursts_total", cs_rises, 2);
    chk("sb_after_busy_test", sb.size(), 0);

    // Abort during the third byte of a four-byte burst.
    clear_mem();
    mem[50] = 8'h81; mem[51] = 8'h42; mem[52] = 8'h24; mem[53] = 8'h18;
    push_exp(8'h81, 1'b0, 7'd50);
    push_exp(8'h42, 1'b0, 7'd51);
    push_exp(8'h24, 1'b0, 7'd52);
    push_exp(8'h18, 1'b1, 7'd53);
    base = n_valid;
    req_addr = 7'd50; req_len = 4'd3; req_valid = 1'b1;
    wait_accept();
    t = 0;
    while ((n_valid - base) < 2 && t < 3000) begin
      step();
      t++;
    end
    if ((n_valid - base) < 2) tmo("abort_two_bytes");
    repeat (20) step();
    rst = 1'b1;
    #1;
    chk("abort_cs", 32'(cs), 0);
    chk("abort_spi_clk", 32'(spi_clk), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (3) step();
    rst = 1'b0;
    chk("abort_valid_count", n_valid - base, 2);
    sb.delete();
    step();
    do_burst(1);

    // Reset held for three clocks in the middle of a command phase.
    clear_mem();
    mem[5] = 8'hEE; mem[6] = 8'h77;
    push_exp(8'hEE, 1'b0, 7'd5);
    push_exp(8'h77, 1'b1, 7'd6);
    base = n_valid;
    req_addr = 7'd5; req_len = 4'd1; req_valid = 1'b1;
    wait_accept();
    repeat (60) step();
    rst = 1'b1;
    #1;
    chk("midrst_cs", 32'(cs), 0);
    chk("midrst_spi_clk", 32'(spi_clk), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rd_valid", 32'(rd_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    repeat (3) step();
    rst = 1'b0;
    sb.delete();
    step();
    chk("midrst_ready_after", 32'(req_ready), 1);
    chk("midrst_no_valid", n_valid - base, 0);
    do_burst(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
